// File: rtl/sort_wbuf.sv
// sort_wbuf: packs sorted elements into DRAM blocks and writes them out in BURST-block requests (D_REQ 2 cycles after the BURST-th push).
// Backpressure: IN_FULL while the block FIFO is full; each D_W pops one block. Optional SORT_WBUF_ERRCHK_EN builds protocol checks on ERROR.
module sort_wbuf #(
  parameter int          DRAMW     = 512,
  parameter int          ELEMW     = 32,
  parameter int          BURST     = 4,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] LAST_ADDR = 32'h07FF_FFF8,
  parameter logic [1:0]  REQ_WRITE = 2'b10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      BASE_ADR,
  input  logic             IN_ENQ,
  input  logic [ELEMW-1:0] IN_DATA,
  output logic             IN_FULL,
  input  logic             FLUSH,
  output logic             DONE,
  input  logic             D_BUSY,
  input  logic             D_W,
  output logic [1:0]       D_REQ,
  output logic [31:0]      D_INITADR,
  output logic [31:0]      D_BLOCKS,
  output logic [DRAMW-1:0] D_DIN,
  output logic             ERROR
);

  localparam int K  = DRAMW / ELEMW;
  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_SLOT = PW'(K - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   BURST_CNT = (AW + 1)'(BURST);

  typedef enum logic [1:0] {IDLE, PAD, REQ, WRITE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    pack_cnt;
  logic [DRAMW-1:0] pack_buf;
  logic [DRAMW-1:0] blk_next;
  logic [DRAMW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             push, push_req, pop;
  logic             flush_pend;
  logic [31:0]      cur_adr;
  logic [31:0]      rem;
  logic             load_req;
  logic [31:0]      nblk_sel;
  logic             done_c;

  assign IN_FULL = (fifo_cnt == FULL_CNT);
  assign pop     = (state == WRITE) && D_W && (fifo_cnt != '0);

  // Unfilled slots are kept at all-ones so a padded block is just the current buffer.
  always_comb begin
    blk_next = pack_buf;
    if (IN_ENQ) begin
      blk_next[pack_cnt*ELEMW +: ELEMW] = IN_DATA;
    end
  end

  assign push_req = (IN_ENQ && (pack_cnt == LAST_SLOT)) || (state == PAD);
  assign push     = push_req && (!IN_FULL || pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pack_cnt <= '0;
      pack_buf <= '1;
    end else if (push_req) begin
      pack_cnt <= '0;
      pack_buf <= '1;
    end else if (IN_ENQ) begin
      pack_cnt <= pack_cnt + 1'b1;
      pack_buf <= blk_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= blk_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    nblk_sel  = '0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if ((fifo_cnt >= BURST_CNT) && !D_BUSY) begin
          state_nxt = REQ;
          load_req  = 1'b1;
          nblk_sel  = 32'(BURST);
        end else if (flush_pend && (pack_cnt != '0)) begin
          // Pad only when the block has somewhere to go.
          if (!IN_FULL) state_nxt = PAD;
        end else if (flush_pend && (fifo_cnt != '0)) begin
          if (!D_BUSY) begin
            state_nxt = REQ;
            load_req  = 1'b1;
            nblk_sel  = 32'(fifo_cnt);
          end
        end else if (flush_pend) begin
          done_c = !START;
        end
      end
      PAD:   state_nxt = IDLE;
      REQ:   state_nxt = WRITE;
      WRITE: if (pop && (rem == 32'd1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign DONE = done_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      cur_adr    <= '0;
      rem        <= '0;
      D_REQ      <= 2'b00;
      D_INITADR  <= '0;
      D_BLOCKS   <= '0;
      D_DIN      <= '0;
    end else begin
      state <= state_nxt;
      if (FLUSH)       flush_pend <= 1'b1;
      else if (done_c) flush_pend <= 1'b0;
      if (START) begin
        cur_adr <= BASE_ADR;
      end else if (pop) begin
        cur_adr <= (cur_adr == LAST_ADDR) ? 32'd0 : cur_adr + 32'd8;
      end
      if (load_req)  rem <= nblk_sel;
      else if (pop)  rem <= rem - 32'd1;
      D_REQ     <= load_req ? REQ_WRITE : 2'b00;
      D_INITADR <= load_req ? cur_adr : 32'd0;
      D_BLOCKS  <= load_req ? nblk_sel : 32'd0;
      if (pop) D_DIN <= mem[rd_ptr];
    end
  end

`ifdef SORT_WBUF_ERRCHK_EN
  logic error_q;
  logic err_hit;

  always_comb begin
    err_hit = (IN_ENQ && IN_FULL) ||
              (D_W && ((fifo_cnt == '0) || (state != WRITE))) ||
              (START && ((state != IDLE) || (fifo_cnt != '0)));
  end

  always_ff @(posedge CLK) begin
    if (RST)          error_q <= 1'b0;
    else if (err_hit) error_q <= 1'b1;
  end

  assign ERROR = error_q;
`else
  assign ERROR = 1'b0;
`endif

endmodule

// File: doc/sort_wbuf.md
# sort_wbuf

Write-back buffer between the merge tree's final output and the DRAM controller port. It packs sorted 32-bit elements into DRAM blocks and queues them in a block FIFO. It issues BURST-block write requests on the `D_REQ`/`D_INITADR`/`D_BLOCKS` port and streams the blocks out on `D_W`. At end of phase it drains remaining data on `FLUSH`.

## Interface
Parameters:
- `DRAMW`, 512, DRAM block width in bits.
- `ELEMW`, 32, element width; `K = DRAMW/ELEMW` elements per block.
- `BURST`, 4, blocks per full write request.
- `DEPTH`, 8, block FIFO depth (power of two, at least `BURST`).
- `LAST_ADDR`, 32'h07FF_FFF8, last DRAM block address. The address after it wraps to 0.
- `REQ_WRITE`, 2'b10, `D_REQ` write code. The idle code is 2'b00.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock.
- `RST` in 1: synchronous active-high reset.
- `START` in 1: loads `BASE_ADR` and clears `DONE`.
- `BASE_ADR` in 32: first block address of the output region.
- `IN_ENQ` in 1: element valid.
- `IN_DATA` in `ELEMW`: element.
- `IN_FULL` out 1: block FIFO full; `IN_ENQ` is forbidden while high.
- `FLUSH` in 1: one-cycle pulse marking the end of the stream.
- `DONE` out 1: one-cycle pulse when everything is written after `FLUSH`.
- `D_BUSY` in 1: controller busy.
- `D_W` in 1: controller consumes one block this cycle.
- `D_REQ` out 2: request code.
- `D_INITADR` out 32: request start address.
- `D_BLOCKS` out 32: request block count.
- `D_DIN` out `DRAMW`: write data, registered.
- `ERROR` out 1: sticky error flag.

## Operation
Packer:
- Element n of a block occupies bits `[n*ELEMW +: ELEMW]`; element 0 is the first received.
- On the K-th `IN_ENQ` the completed block is pushed to the FIFO in the same cycle and the packer count returns to 0.

FSM states:
- `IDLE`:
  - If `fifo_cnt >= BURST` and `!D_BUSY`, go to `REQ` with `nblk = BURST`.
  - Otherwise, if `flush_pend` is set and the packer is partial, go to `PAD`.
  - Otherwise, if `flush_pend` is set, the packer is empty and `fifo_cnt > 0`, go to `REQ` with `nblk = fifo_cnt`.
  - Otherwise, if `flush_pend` is set and the FIFO is empty, pulse `DONE`, clear `flush_pend`, and stay in `IDLE`.
- `PAD`: fill the remaining packer slots with all-ones (maximum key, keeps order), push the block, return to `IDLE`. Takes 1 cycle.
- `REQ`: `D_REQ = REQ_WRITE`, `D_INITADR = cur_adr`, `D_BLOCKS = nblk` for exactly one cycle, then go to `WRITE`.
- `WRITE`:
  - Each `D_W`: pop the FIFO head into `D_DIN`, decrement `rem`, advance `cur_adr` (`LAST_ADDR` → 0, otherwise +8).
  - When `rem` reaches 0, go to `IDLE`.

Other rules:
- `FLUSH` sets `flush_pend`. Input accepted after `FLUSH` but before `DONE` is still written in order.
- `START` sets `cur_adr = BASE_ADR`. `START` is only legal in `IDLE` with an empty FIFO.
- A push and a pop in the same cycle leave `fifo_cnt` unchanged.
- `RST` mid-burst abandons the burst. The FIFO, packer and `flush_pend` are cleared; the controller is reset by the same `RST`.

## Timing
- Reset values: `D_REQ` = 0, `D_INITADR` = 0, `D_BLOCKS` = 0, `D_DIN` = 0, `DONE` = 0, `ERROR` = 0, `IN_FULL` = 0, `cur_adr` = 0, state `IDLE`.
- `IN_FULL` is combinational: `fifo_cnt == DEPTH`.
- Minimum request latency: the BURST-th block is pushed in cycle t, `IDLE` decides in t+1, `D_REQ` is high in t+2.
- `D_DIN` is registered and is valid in the cycle after the `D_W` that popped it. This matches the controller latching write data one cycle after `D_W`.
- A `D_W` in cycle t frees a FIFO slot in t+1, so `IN_FULL` drops in t+1.
- Back-to-back bursts: `IDLE` waits for `D_BUSY` to be low before `REQ`. There is a gap of at least 1 cycle between bursts.
- Sustained throughput is 1 block per `D_W`.

## Configuration
- `SORT_WBUF_ERRCHK_EN` defined:
  - `ERROR` sets on `IN_ENQ` while `IN_FULL`.
  - `ERROR` sets on `D_W` while the FIFO is empty or the state is not `WRITE`.
  - `ERROR` sets on `START` outside an empty `IDLE`.
  - `ERROR` stays set until `RST`.
- Not defined: `ERROR` is tied to 0 and no check logic is built.

## Test plan
- Reset, `BASE_ADR` = 0x100, `START`, 64 elements (4 blocks, K=16) with `D_W` always granted → one request: addr 0x100, blocks 4. Memory holds the elements in order; the next `D_INITADR` is 0x120.
- 20 elements then `FLUSH` → a 2-block request at the current address. Block 2 has elements 16–19 followed by 12 values of 0xFFFFFFFF. `DONE` pulses once after the last `D_W`.
- `cur_adr` = `LAST_ADDR` - 8 with a 4-block burst → blocks are written to `LAST_ADDR`-8, `LAST_ADDR`, 0, 8.
- `D_W` stalled while 128 elements stream in → `IN_FULL` rises at 8 queued blocks. With `SORT_WBUF_ERRCHK_EN` defined, forcing an extra `IN_ENQ` sets `ERROR`; without it, `ERROR` stays 0.
- `RST` asserted after 2 of 4 `D_W` → all outputs return to reset values. After restart, `fifo_cnt` is 0 and a fresh 64-element run produces correct data.
- `FLUSH` with the FIFO and packer empty → `DONE` pulses 1 cycle later and no `D_REQ` is issued.
